// File: rtl/udp_test_checker_pkg.sv
// Shared definitions for the UDP test packet generator and checker:
// header geometry, descriptor bit layout, checker states and error-flag positions.
package udp_test_pkg;

  localparam int HEADER_BYTES = 16;
  localparam int SOP_BIT      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } checker_state_t;

  localparam int ERR_HEADER  = 0;
  localparam int ERR_PAYLOAD = 1;
  localparam int ERR_LENGTH  = 2;
  localparam int ERR_FRAMING = 3;

endpackage

// File: rtl/udp_test_checker_if.sv
// Descriptor stream between the packet source and the checker:
// 9-bit words (SOP flag + byte), valid from the source, ready back from the sink.
interface udp_test_checker_if;
  import udp_test_pkg::*;

  logic [SOP_BIT:0] packet_data;
  logic             packet_data_valid;
  logic             packet_data_enable;

  modport master (output packet_data, output packet_data_valid, input packet_data_enable);
  modport slave  (input packet_data, input packet_data_valid, output packet_data_enable);

endinterface

// File: rtl/udp_test_checker_counter.sv
// Saturating up-counter used for the good/bad packet tallies.
module saturating_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  // Count up on increment, holding at all-ones
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= {WIDTH{1'b0}};
    end else if (increment && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/udp_test_checker.sv
// Receive-side checker for UDP test packets: parses the 16-byte header, verifies the
// incrementing payload pattern and reports per-packet results plus good/bad counts.
module udp_test_checker
  import udp_test_pkg::*;
#(
  parameter logic [15:0] EXPECTED_UDP_SOURCE = 16'h8888,
  parameter int          MAX_PAYLOAD         = 1024,
  parameter int          COUNTER_WIDTH       = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  udp_test_checker_if.slave        stream,
  input  logic [47:0]              expected_mac_destination,
  input  logic [31:0]              expected_ipv4_destination,
  input  logic [15:0]              expected_udp_destination,
  output logic [47:0]              mac_destination,
  output logic [31:0]              ipv4_destination,
  output logic [15:0]              payload_length,
  output logic [15:0]              udp_source,
  output logic [15:0]              udp_destination,
  output logic                     packet_done,
  output logic                     packet_good,
  output logic [3:0]               error_flags,
  output logic [COUNTER_WIDTH-1:0] good_count,
  output logic [COUNTER_WIDTH-1:0] bad_count
);

  localparam logic [3:0] FRAMING_FLAG = 4'(1 << ERR_FRAMING);
  localparam logic [3:0] PAYLOAD_FLAG = 4'(1 << ERR_PAYLOAD);

  checker_state_t state, state_next;
  logic        ready;
  logic [3:0]  byte_idx;
  logic [15:0] payload_count;
  logic [3:0]  err, err_next, fin_flags, hdr_flags;
  logic        accept, sop, start, finish, last_header, hdr_mismatch, pay_mismatch;
  logic [7:0]  data_byte;

  assign stream.packet_data_enable = ready;
  assign accept       = stream.packet_data_valid && ready;
  assign sop          = stream.packet_data[SOP_BIT];
  assign data_byte    = stream.packet_data[7:0];
  assign last_header  = (byte_idx == 4'(HEADER_BYTES - 1));
  // On the last header byte the destination port's low byte is still on the bus
  assign hdr_mismatch = (mac_destination != expected_mac_destination) ||
                        (ipv4_destination != expected_ipv4_destination) ||
                        (udp_source != EXPECTED_UDP_SOURCE) ||
                        ({udp_destination[15:8], data_byte} != expected_udp_destination);
  assign pay_mismatch = (data_byte != payload_count[7:0]);

  // Header-check error bits
  always_comb begin
    hdr_flags             = 4'b0000;
    hdr_flags[ERR_HEADER] = hdr_mismatch;
    hdr_flags[ERR_LENGTH] = (payload_length > 16'(MAX_PAYLOAD));
  end

  // Next-state, packet start/finish strobes and error accumulation
  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    err_next   = err;
    fin_flags  = err;
    if (accept) begin
      case (state)
        IDLE: begin
          if (sop) begin
            start      = 1'b1;
            state_next = HEADER;
          end else begin
            state_next = IDLE;
          end
        end
        HEADER, PAYLOAD: begin
          if (sop) begin
            finish     = 1'b1;
            fin_flags  = err | FRAMING_FLAG;
            start      = 1'b1;
            state_next = HEADER;
          end else if (state == HEADER) begin
            if (last_header) begin
              err_next = err | hdr_flags;
              if (hdr_flags[ERR_LENGTH]) begin
                state_next = DROP;
              end else if (payload_length == 16'd0) begin
                finish     = 1'b1;
                fin_flags  = err_next;
                state_next = IDLE;
              end else begin
                state_next = PAYLOAD;
              end
            end else begin
              state_next = HEADER;
            end
          end else begin
            err_next = err | (pay_mismatch ? PAYLOAD_FLAG : 4'b0000);
            if (payload_count == (payload_length - 16'd1)) begin
              finish     = 1'b1;
              fin_flags  = err_next;
              state_next = IDLE;
            end else begin
              state_next = PAYLOAD;
            end
          end
        end
        DROP: begin
          if (sop) begin
            finish     = 1'b1;
            start      = 1'b1;
            state_next = HEADER;
          end else begin
            state_next = DROP;
          end
        end
        default: state_next = IDLE;
      endcase
      err_next = start ? 4'b0000 : err_next;
    end else begin
      state_next = state;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ready, field capture, payload counter and per-packet result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ready            <= 1'b0;
      err              <= 4'b0000;
      byte_idx         <= 4'd0;
      payload_count    <= 16'd0;
      mac_destination  <= 48'd0;
      ipv4_destination <= 32'd0;
      payload_length   <= 16'd0;
      udp_source       <= 16'd0;
      udp_destination  <= 16'd0;
      packet_done      <= 1'b0;
      packet_good      <= 1'b0;
      error_flags      <= 4'b0000;
    end else begin
      ready       <= enable;
      err         <= err_next;
      packet_done <= finish;
      if (finish) begin
        packet_good <= (fin_flags == 4'b0000);
        error_flags <= fin_flags;
      end
      if (start) begin
        mac_destination[47:40] <= data_byte;
        byte_idx               <= 4'd1;
      end else if (accept && (state == HEADER)) begin
        byte_idx      <= byte_idx + 4'd1;
        payload_count <= 16'd0;
        case (byte_idx)
          4'd1:    mac_destination[39:32]  <= data_byte;
          4'd2:    mac_destination[31:24]  <= data_byte;
          4'd3:    mac_destination[23:16]  <= data_byte;
          4'd4:    mac_destination[15:8]   <= data_byte;
          4'd5:    mac_destination[7:0]    <= data_byte;
          4'd6:    ipv4_destination[31:24] <= data_byte;
          4'd7:    ipv4_destination[23:16] <= data_byte;
          4'd8:    ipv4_destination[15:8]  <= data_byte;
          4'd9:    ipv4_destination[7:0]   <= data_byte;
          4'd10:   payload_length[15:8]    <= data_byte;
          4'd11:   payload_length[7:0]     <= data_byte;
          4'd12:   udp_source[15:8]        <= data_byte;
          4'd13:   udp_source[7:0]         <= data_byte;
          4'd14:   udp_destination[15:8]   <= data_byte;
          4'd15:   udp_destination[7:0]    <= data_byte;
          default: mac_destination         <= mac_destination;
        endcase
      end else if (accept && (state == PAYLOAD)) begin
        payload_count <= payload_count + 16'd1;
      end
    end
  end

  saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_good_count (
    .clock     (clock),
    .reset     (reset),
    .increment (finish && (fin_flags == 4'b0000)),
    .count     (good_count)
  );

  saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_bad_count (
    .clock     (clock),
    .reset     (reset),
    .increment (finish && (fin_flags != 4'b0000)),
    .count     (bad_count)
  );

endmodule

// File: tb/tb_udp_test_checker.sv
// Directed bench for udp_test_checker: stimulus pushes expected packet results into a
// scoreboard queue, a negedge monitor pops and compares on every packet_done.
module tb_udp_test_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [47:0] exp_mac = 48'h02_00_00_00_00_01;
  logic [31:0] exp_ip  = 32'hC0A8_0001;
  logic [15:0] exp_dst = 16'h1234;

  logic [47:0] mac_destination;
  logic [31:0] ipv4_destination;
  logic [15:0] payload_length, udp_source, udp_destination;
  logic        packet_done, packet_good;
  logic [3:0]  error_flags;
  logic [15:0] good_count, bad_count;

  udp_test_checker_if bus ();

  udp_test_checker #(
    .EXPECTED_UDP_SOURCE (16'h8888),
    .MAX_PAYLOAD         (1024),
    .COUNTER_WIDTH       (16)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .enable                    (enable),
    .stream                    (bus),
    .expected_mac_destination  (exp_mac),
    .expected_ipv4_destination (exp_ip),
    .expected_udp_destination  (exp_dst),
    .mac_destination           (mac_destination),
    .ipv4_destination          (ipv4_destination),
    .payload_length            (payload_length),
    .udp_source                (udp_source),
    .udp_destination           (udp_destination),
    .packet_done               (packet_done),
    .packet_good               (packet_good),
    .error_flags               (error_flags),
    .good_count                (good_count),
    .bad_count                 (bad_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        good;
    logic [3:0]  flags;
    logic [15:0] gcnt;
    logic [15:0] bcnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] pkt[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_good_n = 0;
  int         exp_bad_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_pkt(input logic [3:0] flags);
    exp_t e;
    if (flags == 4'b0000) exp_good_n++;
    else exp_bad_n++;
    e.good  = (flags == 4'b0000);
    e.flags = flags;
    e.gcnt  = 16'(exp_good_n);
    e.bcnt  = 16'(exp_bad_n);
    sb.push_back(e);
  endtask

  task automatic build(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] len,
                       input logic [15:0] src, input logic [15:0] dst, input int npay);
    logic [127:0] h;
    h = {mac, ip, len, src, dst};
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(h[127-8*i -: 8]);
    for (int i = 0; i < npay; i++) pkt.push_back(8'(i));
  endtask

  // Presents one word from a negedge and returns at the negedge after it is accepted
  task automatic send(input logic s, input logic [7:0] b);
    logic acc;
    int   guard;
    bus.packet_data       = {s, b};
    bus.packet_data_valid = 1'b1;
    guard = 0;
    do begin
      acc = bus.packet_data_enable;
      @(negedge clock);
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready still 0 after %0d cycles, required 1", guard);
    end
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send(i == 0, pkt[i]);
    bus.packet_data_valid = 1'b0;
  endtask

  task automatic gap();
    if ($urandom_range(0, 1) == 1) begin
      bus.packet_data_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clock);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_good_n = 0;
    exp_bad_n  = 0;
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 64'(packet_done), 64'd0);
    check({tag, "_good"}, 64'(packet_good), 64'd0);
    check({tag, "_flags"}, 64'(error_flags), 64'd0);
    check({tag, "_good_count"}, 64'(good_count), 64'd0);
    check({tag, "_bad_count"}, 64'(bad_count), 64'd0);
    check({tag, "_mac"}, 64'(mac_destination), 64'd0);
    check({tag, "_fields"}, {ipv4_destination, payload_length, udp_source}, 64'd0);
    check({tag, "_udp_dst"}, 64'(udp_destination), 64'd0);
    check({tag, "_ready"}, 64'(bus.packet_data_enable), 64'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (packet_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got packet_done=1 flags=%0b, required no packet", error_flags);
      end else begin
        mon_e = sb.pop_front();
        check("packet_good", 64'(packet_good), 64'(mon_e.good));
        check("error_flags", 64'(error_flags), 64'(mon_e.flags));
        check("good_count", 64'(good_count), 64'(mon_e.gcnt));
        check("bad_count", 64'(bad_count), 64'(mon_e.bcnt));
      end
    end
  end

  initial begin
    reset                 = 1'b1;
    enable                = 1'b1;
    bus.packet_data       = 9'd0;
    bus.packet_data_valid = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Good packet, latency and parsed fields
    build(exp_mac, exp_ip, 16'h0008, 16'h8888, 16'h1234, 8);
    expect_pkt(4'b0000);
    send_range(0, 22);
    check("done_before_last", 64'(packet_done), 64'd0);
    send_range(23, 23);
    check("done_latency", 64'(packet_done), 64'd1);
    check("mac_destination", 64'(mac_destination), 64'h0200_0000_0001);
    check("ipv4_destination", 64'(ipv4_destination), 64'hC0A8_0001);
    check("payload_length", 64'(payload_length), 64'h0008);
    check("udp_source", 64'(udp_source), 64'h8888);
    check("udp_destination", 64'(udp_destination), 64'h1234);
    repeat (2) @(negedge clock);

    // Payload byte 5 corrupted
    build(exp_mac, exp_ip, 16'h0008, 16'h8888, 16'h1234, 8);
    pkt[21] = 8'hFF;
    expect_pkt(4'b0010);
    send_range(0, 23);
    repeat (2) @(negedge clock);

    // Wrong destination port
    build(exp_mac, exp_ip, 16'h0008, 16'h8888, 16'h1235, 8);
    expect_pkt(4'b0001);
    send_range(0, 23);
    check("udp_dst_parsed", 64'(udp_destination), 64'h1235);
    repeat (2) @(negedge clock);

    // SOP after 10 bytes aborts, following packet is good
    pulse_reset();
    build(exp_mac, exp_ip, 16'h0008, 16'h8888, 16'h1234, 8);
    send_range(0, 9);
    expect_pkt(4'b1000);
    expect_pkt(4'b0000);
    send_range(0, 0);
    check("abort_done_immediate", 64'(packet_done), 64'd1);
    send_range(1, 23);
    repeat (2) @(negedge clock);

    // Oversized length dropped until next SOP
    build(exp_mac, exp_ip, 16'h0800, 16'h8888, 16'h1234, 0);
    send_range(0, 15);
    for (int i = 0; i < 20; i++) send(1'b0, 8'(8'hA5 ^ i));
    bus.packet_data_valid = 1'b0;
    repeat (3) @(negedge clock);
    build(exp_mac, exp_ip, 16'h0004, 16'h8888, 16'h1234, 4);
    expect_pkt(4'b0100);
    expect_pkt(4'b0000);
    send_range(0, 19);
    repeat (2) @(negedge clock);

    // Zero-length packet with valid gaps and a 20-cycle enable stall mid-header
    build(exp_mac, exp_ip, 16'h0000, 16'h8888, 16'h1234, 0);
    expect_pkt(4'b0000);
    for (int i = 0; i < 7; i++) begin
      send(i == 0, pkt[i]);
      gap();
    end
    bus.packet_data_valid = 1'b0;
    enable = 1'b0;
    check("ready_lag_hold", 64'(bus.packet_data_enable), 64'd1);
    @(negedge clock);
    check("ready_lag_drop", 64'(bus.packet_data_enable), 64'd0);
    bus.packet_data       = {1'b0, pkt[7]};
    bus.packet_data_valid = 1'b1;
    repeat (19) @(negedge clock);
    enable = 1'b1;
    check("ready_still_low", 64'(bus.packet_data_enable), 64'd0);
    @(negedge clock);
    check("ready_lag_rise", 64'(bus.packet_data_enable), 64'd1);
    for (int i = 7; i < 16; i++) begin
      send(1'b0, pkt[i]);
      gap();
    end
    bus.packet_data_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("good_count_total", 64'(good_count), 64'd3);
    check("bad_count_total", 64'(bad_count), 64'd2);

    // Reset in mid-payload: no packet_done, all outputs cleared
    build(exp_mac, exp_ip, 16'h0008, 16'h8888, 16'h1234, 8);
    send_range(0, 18);
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("post_reset_count", 64'(good_count + bad_count), 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
